// File: rtl/nano_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nano_cpu_pkg
// Description : Shared widths, load funct3 encodings and scoreboard helper
//               for the nano-cpu pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package nano_cpu_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // A register is busy while a load to it is outstanding or while its write
  // is sitting in the output register (not yet captured by the file).
  function automatic logic reg_busy(input logic [31:0]          pending,
                                    input logic                 out_valid,
                                    input logic [REG_IDX_W-1:0] out_sel,
                                    input logic [REG_IDX_W-1:0] idx);
    return pending[idx] | (out_valid && (out_sel == idx) && (idx != '0));
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Extracts the addressed byte/halfword from an aligned memory
//               word, sign/zero-extends it, and flags misaligned or illegal
//               load encodings.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import nano_cpu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] value,
  output logic            err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = data[{addr_lo, 3'b000} +: 8];
  assign w_half = addr_lo[1] ? data[31:16] : data[15:0];

  // Format the selected lane by load type; anything unrecognised is an error.
  always_comb begin
    value = '0;
    err   = 1'b0;
    case (funct3)
      F3_LB:  value = {{24{w_byte[7]}}, w_byte};
      F3_LBU: value = {24'h0, w_byte};
      F3_LH: begin
        value = {{16{w_half[15]}}, w_half};
        err   = addr_lo[0];
      end
      F3_LHU: begin
        value = {16'h0, w_half};
        err   = addr_lo[0];
      end
      F3_LW: begin
        value = data;
        err   = (addr_lo != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Final pipeline stage. Arbitrates load responses over ALU
//               results, formats load data, registers one register-file
//               write per cycle and tracks outstanding loads for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
  import nano_cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [4:0]           alu_rd_select,
  input  logic [XLEN-1:0]      alu_result,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [4:0]           ld_rd_select,
  input  logic [2:0]           ld_funct3,
  input  logic [1:0]           ld_addr_lo,
  input  logic [XLEN-1:0]      ld_data,
  input  logic                 ld_issue_valid,
  input  logic [4:0]           ld_issue_rd,
  input  logic [4:0]           rs1_select,
  input  logic [4:0]           rs2_select,
  input  logic [4:0]           rd_select,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rd_busy,
  output logic                 ld_error,
  output logic                 reg_rd_valid,
  output logic [4:0]           reg_rd_select,
  output logic [XLEN-1:0]      reg_rd
);

  logic            w_ld_fire;
  logic            w_alu_fire;
  logic [XLEN-1:0] w_ld_value;
  logic            w_ld_err;
  logic            w_write;
  logic [4:0]      w_wr_sel;
  logic [XLEN-1:0] w_wr_data;
  logic [31:0]     w_pending_next;

  logic            r_valid;
  logic [4:0]      r_sel;
  logic [XLEN-1:0] r_data;
  logic            r_ld_error;
  logic [31:0]     r_pending;

  load_align u_load_align (
    .funct3  (ld_funct3),
    .addr_lo (ld_addr_lo),
    .data    (ld_data),
    .value   (w_ld_value),
    .err     (w_ld_err)
  );

  // Loads always win; the load path never back-pressures.
  assign ld_ready   = 1'b1;
  assign alu_ready  = !ld_valid;
  assign w_ld_fire  = ld_valid;
  assign w_alu_fire = alu_valid && !ld_valid;

  // Pick the winning transfer and decide whether it produces a write.
  always_comb begin
    w_wr_sel  = alu_rd_select;
    w_wr_data = alu_result;
    w_write   = 1'b0;
    if (w_ld_fire) begin
      w_wr_sel  = ld_rd_select;
      w_wr_data = w_ld_value;
      w_write   = (ld_rd_select != 5'd0) && !w_ld_err;
    end else if (w_alu_fire) begin
      w_write   = (alu_rd_select != 5'd0);
    end
  end

  // Retire clears the load's bit; a same-cycle issue to that index re-sets it.
  always_comb begin
    w_pending_next = r_pending;
    if (w_ld_fire) begin
      w_pending_next[ld_rd_select] = 1'b0;
    end
    if (ld_issue_valid && (ld_issue_rd != 5'd0)) begin
      w_pending_next[ld_issue_rd] = 1'b1;
    end
    w_pending_next[0] = 1'b0;
  end

  // Output register: index/data hold when no write is produced.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_sel      <= '0;
      r_data     <= '0;
      r_ld_error <= 1'b0;
      r_pending  <= '0;
    end else begin
      r_valid    <= w_write;
      r_ld_error <= w_ld_fire && w_ld_err;
      r_pending  <= w_pending_next;
      if (w_write) begin
        r_sel  <= w_wr_sel;
        r_data <= w_wr_data;
      end
    end
  end

  assign reg_rd_valid  = r_valid;
  assign reg_rd_select = r_sel;
  assign reg_rd        = r_data;
  assign ld_error      = r_ld_error;

  assign rs1_busy = reg_busy(r_pending, r_valid, r_sel, rs1_select);
  assign rs2_busy = reg_busy(r_pending, r_valid, r_sel, rs2_select);
  assign rd_busy  = reg_busy(r_pending, r_valid, r_sel, rd_select);

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Directed and randomized checks of writeback_stage against a
//               behavioural model of the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd_select = '0;
  logic [31:0] alu_result = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd_select = '0;
  logic [2:0]  ld_funct3 = '0;
  logic [1:0]  ld_addr_lo = '0;
  logic [31:0] ld_data = '0;
  logic        ld_issue_valid = 1'b0;
  logic [4:0]  ld_issue_rd = '0;
  logic [4:0]  rs1_select = '0;
  logic [4:0]  rs2_select = '0;
  logic [4:0]  rd_select = '0;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic        ld_error;
  logic        reg_rd_valid;
  logic [4:0]  reg_rd_select;
  logic [31:0] reg_rd;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  writeback_stage #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd_select  (alu_rd_select),
    .alu_result     (alu_result),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_rd_select   (ld_rd_select),
    .ld_funct3      (ld_funct3),
    .ld_addr_lo     (ld_addr_lo),
    .ld_data        (ld_data),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_rd    (ld_issue_rd),
    .rs1_select     (rs1_select),
    .rs2_select     (rs2_select),
    .rd_select      (rd_select),
    .rs1_busy       (rs1_busy),
    .rs2_busy       (rs2_busy),
    .rd_busy        (rd_busy),
    .ld_error       (ld_error),
    .reg_rd_valid   (reg_rd_valid),
    .reg_rd_select  (reg_rd_select),
    .reg_rd         (reg_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load formatting from plain arithmetic: bit 32 = error.
  function automatic logic [32:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    int b;
    int h;
    logic [31:0] v;
    logic e;
    b = int'((d >> (8 * int'(a))) & 32'hFF);
    h = int'((d >> (16 * (int'(a) / 2))) & 32'hFFFF);
    v = 32'h0;
    e = 1'b0;
    case (int'(f3))
      0: v = 32'(b >= 128 ? b - 256 : b);
      4: v = 32'(b);
      1: begin v = 32'(h >= 32768 ? h - 65536 : h); e = (int'(a) % 2) != 0; end
      5: begin v = 32'(h); e = (int'(a) % 2) != 0; end
      2: begin v = d; e = (a != 2'd0); end
      default: e = 1'b1;
    endcase
    return {e, v};
  endfunction

  // Model state: the write on the register-file port and the set of
  // registers with loads outstanding.
  logic        m_valid = 1'b0;
  logic [4:0]  m_sel   = '0;
  logic [31:0] m_data  = '0;
  logic        m_err   = 1'b0;
  logic [31:0] m_pend  = '0;

  logic [32:0] t_ld;
  logic        t_write;
  logic [4:0]  t_sel;
  logic [31:0] t_data;
  logic [31:0] t_pend;

  always_comb begin
    t_ld    = ref_load(ld_funct3, ld_addr_lo, ld_data);
    t_write = 1'b0;
    t_sel   = m_sel;
    t_data  = m_data;
    t_pend  = m_pend;
    if (ld_valid) begin
      t_pend[ld_rd_select] = 1'b0;
      if (ld_rd_select != 0 && !t_ld[32]) begin
        t_write = 1'b1; t_sel = ld_rd_select; t_data = t_ld[31:0];
      end
    end else if (alu_valid && alu_rd_select != 0) begin
      t_write = 1'b1; t_sel = alu_rd_select; t_data = alu_result;
    end
    if (ld_issue_valid && ld_issue_rd != 0) t_pend[ld_issue_rd] = 1'b1;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0; m_sel <= '0; m_data <= '0; m_err <= 1'b0; m_pend <= '0;
    end else begin
      m_valid <= t_write;
      m_sel   <= t_sel;
      m_data  <= t_data;
      m_err   <= ld_valid && t_ld[32];
      m_pend  <= t_pend;
    end
  end

  function automatic logic exp_busy(input logic [4:0] x);
    return m_pend[x] || (m_valid && m_sel == x && x != 0);
  endfunction

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    if (check_en) begin
      chk("reg_rd_valid", 32'(reg_rd_valid), 32'(m_valid));
      chk("reg_rd_select", 32'(reg_rd_select), 32'(m_sel));
      chk("reg_rd", reg_rd, m_data);
      chk("ld_error", 32'(ld_error), 32'(m_err));
      chk("alu_ready", 32'(alu_ready), 32'(!ld_valid));
      chk("ld_ready", 32'(ld_ready), 32'd1);
      chk("rs1_busy", 32'(rs1_busy), 32'(exp_busy(rs1_select)));
      chk("rs2_busy", 32'(rs2_busy), 32'(exp_busy(rs2_select)));
      chk("rd_busy", 32'(rd_busy), 32'(exp_busy(rd_select)));
    end
  end

  task automatic idle();
    alu_valid = 1'b0; ld_valid = 1'b0; ld_issue_valid = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic look();
    @(negedge clk); #1;
  endtask
  task automatic drive_ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a,
                          input logic [31:0] d);
    ld_valid = 1'b1; ld_rd_select = rd; ld_funct3 = f3; ld_addr_lo = a; ld_data = d;
  endtask

  logic [2:0]  fmt_f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
  logic [1:0]  fmt_a   [4] = '{2'd3, 2'd3, 2'd2, 2'd0};
  logic [31:0] fmt_exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check_en = 1'b1;
    look();
    chk("reset valid", 32'(reg_rd_valid), 32'd0);
    chk("reset select", 32'(reg_rd_select), 32'd0);
    chk("reset data", reg_rd, 32'd0);
    chk("reset ld_error", 32'(ld_error), 32'd0);

    // ALU only
    alu_valid = 1'b1; alu_rd_select = 5'd5; alu_result = 32'hDEADBEEF;
    tick(); idle(); look();
    chk("alu valid", 32'(reg_rd_valid), 32'd1);
    chk("alu select", 32'(reg_rd_select), 32'd5);
    chk("alu data", reg_rd, 32'hDEADBEEF);
    tick(); look();
    chk("alu valid drop", 32'(reg_rd_valid), 32'd0);

    // Collision: load first, ALU one cycle later
    alu_valid = 1'b1; alu_rd_select = 5'd3; alu_result = 32'hAAAA5555;
    drive_ld(5'd4, 3'b010, 2'd0, 32'h12345678);
    #1 chk("collision alu_ready", 32'(alu_ready), 32'd0);
    tick(); ld_valid = 1'b0; look();
    chk("collision first select", 32'(reg_rd_select), 32'd4);
    chk("collision first data", reg_rd, 32'h12345678);
    tick(); idle(); look();
    chk("collision second select", 32'(reg_rd_select), 32'd3);
    chk("collision second data", reg_rd, 32'hAAAA5555);

    // Load formatting
    for (int i = 0; i < 4; i++) begin
      drive_ld(5'd10, fmt_f3[i], fmt_a[i], 32'h80FF7F01);
      tick(); idle(); look();
      chk("format data", reg_rd, fmt_exp[i]);
    end

    // Errors
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd12; rs1_select = 5'd12;
    tick(); idle(); look();
    chk("err pending set", 32'(rs1_busy), 32'd1);
    drive_ld(5'd12, 3'b010, 2'd2, 32'h11111111);
    tick(); idle(); look();
    chk("LW misalign error", 32'(ld_error), 32'd1);
    chk("LW misalign no write", 32'(reg_rd_valid), 32'd0);
    chk("LW misalign cleared", 32'(rs1_busy), 32'd0);
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd13; rs1_select = 5'd13;
    tick(); idle(); look();
    chk("error pulse ends", 32'(ld_error), 32'd0);
    drive_ld(5'd13, 3'b001, 2'd1, 32'h22222222);
    tick(); idle(); look();
    chk("LH misalign error", 32'(ld_error), 32'd1);
    chk("LH misalign cleared", 32'(rs1_busy), 32'd0);

    // Scoreboard rd 7
    rs1_select = 5'd7;
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
    tick(); idle(); look();
    chk("rd7 busy after issue", 32'(rs1_busy), 32'd1);
    tick(); look();
    chk("rd7 still busy", 32'(rs1_busy), 32'd1);
    drive_ld(5'd7, 3'b010, 2'd0, 32'h00000077);
    tick(); idle(); look();
    chk("rd7 busy via output", 32'(rs1_busy), 32'd1);
    tick(); look();
    chk("rd7 free", 32'(rs1_busy), 32'd0);

    // Same-cycle issue and retire of rd 9
    rs2_select = 5'd9;
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
    tick(); idle();
    drive_ld(5'd9, 3'b010, 2'd0, 32'h99);
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
    tick(); idle(); tick(); look();
    chk("rd9 set wins", 32'(rs2_busy), 32'd1);
    drive_ld(5'd9, 3'b010, 2'd0, 32'h99);
    tick(); idle(); tick();

    // rd 0 is never busy and never written
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd0; rd_select = 5'd0;
    tick(); idle(); look();
    chk("rd0 never busy", 32'(rd_busy), 32'd0);
    alu_valid = 1'b1; alu_rd_select = 5'd0; alu_result = 32'h5A5A5A5A;
    tick(); idle(); look();
    chk("rd0 no write", 32'(reg_rd_valid), 32'd0);

    // Reset mid-stream
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd20;
    tick(); idle();
    alu_valid = 1'b1; alu_rd_select = 5'd6; alu_result = 32'h66;
    rs1_select = 5'd20; rd_select = 5'd6;
    tick(); look();
    chk("pre-reset valid", 32'(reg_rd_valid), 32'd1);
    chk("pre-reset pending", 32'(rs1_busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("async reset valid", 32'(reg_rd_valid), 32'd0);
    chk("async reset select", 32'(reg_rd_select), 32'd0);
    chk("async reset data", reg_rd, 32'd0);
    chk("async reset pending", 32'(rs1_busy), 32'd0);
    chk("async reset rd_busy", 32'(rd_busy), 32'd0);
    tick(); idle(); rst = 1'b1; look();
    chk("no write after reset", 32'(reg_rd_valid), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      ld_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0 && m_pend != 0) begin
        do ld_rd_select = 5'($urandom); while (!m_pend[ld_rd_select]);
      end else begin
        ld_rd_select = 5'($urandom);
      end
      ld_funct3  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : fmt_f3[$urandom_range(0, 3)];
      if ($urandom_range(0, 4) == 0) ld_funct3 = 3'b010;
      ld_addr_lo = 2'($urandom);
      ld_data    = $urandom;
      alu_valid     = ($urandom_range(0, 1) == 0);
      alu_rd_select = 5'($urandom);
      alu_result    = $urandom;
      ld_issue_rd    = 5'($urandom);
      ld_issue_valid = ($urandom_range(0, 2) == 0) && !m_pend[ld_issue_rd];
      rs1_select = 5'($urandom);
      rs2_select = m_valid ? m_sel : 5'($urandom);
      rd_select  = 5'($urandom);
    end
    tick(); idle(); tick();
    look();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the nano-cpu, sitting directly upstream of the register file write port. It accepts completed results from the ALU and from the data-memory load path, formats load data, and drives exactly one registered write per cycle into the register file. It also keeps a pending-load scoreboard so decode can stall on source or destination registers whose value is not yet written.

## Interface
Parameters:
- `XLEN`, 32, data width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result offered.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `alu_rd_select`  in  5  destination register index.
- `alu_result`  in  32  value to write.
- `ld_valid`  in  1  load response offered.
- `ld_ready`  out  1  load response accepted; tied high.
- `ld_rd_select`  in  5  load destination register.
- `ld_funct3`  in  3  load type: LB 000, LH 001, LW 010, LBU 100, LHU 101.
- `ld_addr_lo`  in  2  byte address bits [1:0] of the load.
- `ld_data`  in  32  raw aligned memory word.
- `ld_issue_valid`  in  1  decode issued a load this cycle.
- `ld_issue_rd`  in  5  destination register of the issued load.
- `rs1_select`, `rs2_select`, `rd_select`  in  5 each  scoreboard query indices.
- `rs1_busy`, `rs2_busy`, `rd_busy`  out  1 each  queried register has a write outstanding.
- `ld_error`  out  1  one-cycle pulse on a misaligned or illegal load.
- `reg_rd_valid`  out  1  register file write enable.
- `reg_rd_select`  out  5  register file write index.
- `reg_rd`  out  32  register file write data.

## Operation
- **Arbitration.** Fixed priority: load over ALU.
  - `alu_ready = !ld_valid`.
  - A transfer occurs when valid && ready.
- **Output register.** `reg_rd_valid`, `reg_rd_select` and `reg_rd` are registered.
  - On a cycle with an accepted transfer whose rd ≠ 0 and which has no error, the next edge loads the output register with valid = 1.
  - Otherwise the next edge clears valid; `reg_rd_select` and `reg_rd` hold their values.
- **rd = 0.** The handshake completes but no write is produced.
- **Load formatting.** Byte lane = `ld_addr_lo`; halfword lane = `ld_addr_lo[1]`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- **Load errors.** Each of the following asserts `ld_error` for one cycle and suppresses the write:
  - LH or LHU with `ld_addr_lo[0]` = 1;
  - LW with `ld_addr_lo` ≠ 0;
  - funct3 of 011, 110 or 111.
  - The handshake still completes and the scoreboard bit still clears.
- **Scoreboard.** A 32-bit `pending` vector.
  - `ld_issue_valid` with `ld_issue_rd` ≠ 0 sets the corresponding bit.
  - An accepted load clears the bit for `ld_rd_select`.
  - Simultaneous set and clear of the same index: set wins.
  - Bit 0 is never set.
  - Decode never issues a load to a register that is already busy.
- **Busy query (combinational).** `x_busy = pending[x] | (reg_rd_valid && reg_rd_select == x && x != 0)`, i.e. pending loads plus the write currently presented to the register file.

## Timing
- Accept at edge N: `reg_rd_valid` is high during cycle N+1 and the register file captures the write at edge N+1.
- The value is readable from the register file in cycle N+2.
- Throughput: one write per cycle. When loads are continuous, the ALU is stalled indefinitely; this is by design.
- `ld_error` is registered and pulses in cycle N+1.
- A scoreboard set at edge N is visible on the busy outputs in cycle N+1. A clear at edge N still reports busy in cycle N+1, via the output-register term, when a write was produced.
- Reset (asynchronous assert, mid-operation included): `reg_rd_valid` = 0, `reg_rd_select` = 0, `reg_rd` = 0, `ld_error` = 0, `pending` = 0.
  - `alu_ready` and `ld_ready` are combinational and follow their equations.
  - In-flight results are dropped.

## Structure
- Shared package `nano_cpu_pkg` holds:
  - load funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`);
  - `REG_IDX_W` = 5;
  - `XLEN`.
- One combinational sub-module, `load_align`: inputs funct3, addr_lo and data; outputs the formatted value and the error flag.
- The scoreboard, arbitration and output register live in the top module.

## Test plan
- ALU only: alu_valid, rd = 5, result 0xDEADBEEF at edge 0 -> cycle 1 shows `reg_rd_valid` = 1, select 5, data 0xDEADBEEF; cycle 2 shows valid = 0.
- Collision: alu and ld valid together (alu rd = 3, LW rd = 4, data 0x12345678) -> `alu_ready` = 0, rd 4 written first; the ALU is accepted the next cycle and rd 3 written one cycle later.
- Load formatting on data 0x80FF7F01:
  - LB addr 3 -> 0xFFFFFF80;
  - LBU addr 3 -> 0x00000080;
  - LH addr 2 -> 0xFFFF80FF;
  - LHU addr 0 -> 0x00007F01.
- Errors: LW addr 2 and LH addr 1 -> `ld_error` pulses, no write, pending bit cleared.
- Scoreboard: issue load rd 7, query rs1 = 7 -> busy from the next cycle until the cycle after the load is written. Same-cycle issue rd 9 plus retire rd 9 -> remains busy. Issue rd 0 -> never busy.
- rd = 0 writes suppressed; `rst` asserted mid-stream with pending bits set and a valid output -> all outputs and `pending` read 0 immediately, with no write after release.
